// File: rtl/gray_hist_stat_tx.sv
// Per-frame grey-level histogram with clear-on-read bin streaming.
// Optional HIST_TOTAL_CNT_EN adds hs_total_cnt (pixels in last frame).
module gray_hist_stat_tx #(
  parameter int SRC_HS_DW = 8,
  parameter int HS_CNT_DW = 32
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 src_hs_hsync,
  input  logic                 src_hs_vsync,
  input  logic [SRC_HS_DW-1:0] src_hs_data_out,
  input  logic                 hs_request,
  output logic                 hs_valid,
  output logic [SRC_HS_DW-1:0] hs_pixel,
  output logic [HS_CNT_DW-1:0] hs_pixel_cnt,
  output logic                 result_rd_ready,
  output logic                 result_wr_done,
`ifdef HIST_TOTAL_CNT_EN
  output logic [HS_CNT_DW-1:0] hs_total_cnt,
`endif
  output logic                 frame_drop
);
  localparam int NB = 1 << SRC_HS_DW;

  typedef enum logic [2:0] {
    S_CLEAR, S_WAIT, S_COUNT, S_DRAIN, S_READY, S_READ
  } state_t;

  state_t state_q, state_d;
  logic [SRC_HS_DW-1:0] addr_q, addr_d;
  logic vs_q, rise, fall;
  logic v1_q, v1_d, v2_q;
  logic [SRC_HS_DW-1:0] a1_q, a2_q, wa_q;
  logic wv_q;
  logic [HS_CNT_DW-1:0] wd_q, base, incr, ram_rd_q;
  logic [HS_CNT_DW-1:0] mem [NB];
  logic we;
  logic [SRC_HS_DW-1:0] waddr, raddr;
  logic [HS_CNT_DW-1:0] wdata;
  logic valid_q, valid_d;
  logic [SRC_HS_DW-1:0] pix_q, pix_d;
  logic wr_done_q, wr_done_d, rd_ready_q, drop_q, drop_d;

  assign rise = src_hs_vsync & ~vs_q;
  assign fall = ~src_hs_vsync & vs_q;

  // Previous-cycle write forwarded to cover the read-old RAM hazard
  assign base = (wv_q && wa_q == a2_q) ? wd_q : ram_rd_q;
  assign incr = (&base) ? base : base + HS_CNT_DW'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_done_d = 1'b0;
    valid_d   = 1'b0;
    pix_d     = '0;
    drop_d    = 1'b0;
    v1_d      = src_hs_hsync && src_hs_vsync &&
                (state_q == S_COUNT || (state_q == S_WAIT && rise));
    we        = v2_q;
    waddr     = a2_q;
    wdata     = incr;
    raddr     = a1_q;
    unique case (state_q)
      S_CLEAR: begin
        we     = 1'b1;
        waddr  = addr_q;
        wdata  = '0;
        addr_d = addr_q + SRC_HS_DW'(1);
        drop_d = rise;
        if (&addr_q) state_d = S_WAIT;
      end
      S_WAIT: if (rise) state_d = S_COUNT;
      S_COUNT: if (fall) state_d = S_DRAIN;
      S_DRAIN: begin
        drop_d = rise;
        if (!v1_q && !v2_q) begin
          wr_done_d = 1'b1;
          state_d   = S_READY;
        end
      end
      S_READY: begin
        drop_d = rise;
        if (hs_request) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        drop_d  = rise;
        we      = 1'b1;
        waddr   = addr_q;
        wdata   = '0;
        raddr   = addr_q;
        valid_d = 1'b1;
        pix_d   = addr_q;
        addr_d  = addr_q + SRC_HS_DW'(1);
        if (&addr_q) state_d = S_WAIT;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
    ram_rd_q <= mem[raddr];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      addr_q     <= '0;
      vs_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      a1_q       <= '0;
      a2_q       <= '0;
      wv_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      valid_q    <= 1'b0;
      pix_q      <= '0;
      wr_done_q  <= 1'b0;
      rd_ready_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vs_q       <= src_hs_vsync;
      v1_q       <= v1_d;
      v2_q       <= v1_q;
      a1_q       <= src_hs_data_out;
      a2_q       <= a1_q;
      wv_q       <= v2_q;
      wa_q       <= a2_q;
      wd_q       <= incr;
      valid_q    <= valid_d;
      pix_q      <= pix_d;
      wr_done_q  <= wr_done_d;
      rd_ready_q <= wr_done_q;
      drop_q     <= drop_d;
    end
  end

  assign hs_valid        = valid_q;
  assign hs_pixel        = pix_q;
  assign hs_pixel_cnt    = valid_q ? ram_rd_q : '0;
  assign result_wr_done  = wr_done_q;
  assign result_rd_ready = rd_ready_q;
  assign frame_drop      = drop_q;

`ifdef HIST_TOTAL_CNT_EN
  logic [HS_CNT_DW-1:0] acc_q, acc_d, tot_q, tot_d;

  always_comb begin
    acc_d = acc_q;
    tot_d = tot_q;
    if (state_q == S_WAIT && rise) acc_d = '0;
    else if (v2_q && !(&acc_q)) acc_d = acc_q + HS_CNT_DW'(1);
    if (wr_done_d) tot_d = acc_q;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      tot_q <= '0;
    end else begin
      acc_q <= acc_d;
      tot_q <= tot_d;
    end
  end

  assign hs_total_cnt = tot_q;
`endif
endmodule

// File: tb/tb_gray_hist_stat_tx.sv
// Directed bench for gray_hist_stat_tx: 32-bit and 4-bit counter builds
// share stimulus; readouts are checked against a queued scoreboard.
module tb_gray_hist_stat_tx;
  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic hsync = 1'b0, vsync = 1'b0, req = 1'b0;
  logic [7:0] data = '0;

  logic a_valid, a_rdy, a_done, a_drop;
  logic [7:0] a_pix;
  logic [31:0] a_cnt;
  logic b_valid, b_rdy, b_done, b_drop;
  logic [7:0] b_pix;
  logic [3:0] b_cnt;
`ifdef HIST_TOTAL_CNT_EN
  logic [31:0] a_tot;
  logic [3:0] b_tot;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned hist [256];
  logic [39:0] q32 [$];
  logic [11:0] q4 [$];

  gray_hist_stat_tx #(.SRC_HS_DW(8), .HS_CNT_DW(32)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .src_hs_hsync(hsync), .src_hs_vsync(vsync),
    .src_hs_data_out(data), .hs_request(req),
    .hs_valid(a_valid), .hs_pixel(a_pix), .hs_pixel_cnt(a_cnt),
    .result_rd_ready(a_rdy), .result_wr_done(a_done),
`ifdef HIST_TOTAL_CNT_EN
    .hs_total_cnt(a_tot),
`endif
    .frame_drop(a_drop));

  gray_hist_stat_tx #(.SRC_HS_DW(8), .HS_CNT_DW(4)) dut4 (
    .pclk(pclk), .rst_n(rst_n),
    .src_hs_hsync(hsync), .src_hs_vsync(vsync),
    .src_hs_data_out(data), .hs_request(req),
    .hs_valid(b_valid), .hs_pixel(b_pix), .hs_pixel_cnt(b_cnt),
    .result_rd_ready(b_rdy), .result_wr_done(b_done),
`ifdef HIST_TOTAL_CNT_EN
    .hs_total_cnt(b_tot),
`endif
    .frame_drop(b_drop));

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    logic [39:0] e32;
    logic [11:0] e4;
    if (a_valid) begin
      e32 = (q32.size() != 0) ? q32.pop_front() : 'x;
      checks++;
      assert ({a_pix, a_cnt} === e32) else begin
        errors++;
        $error("FAIL bin32 got %h exp %h", {a_pix, a_cnt}, e32);
      end
    end
    if (b_valid) begin
      e4 = (q4.size() != 0) ? q4.pop_front() : 'x;
      checks++;
      assert ({b_pix, b_cnt} === e4) else begin
        errors++;
        $error("FAIL bin4 got %h exp %h", {b_pix, b_cnt}, e4);
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sat4(input int unsigned v);
    return (v > 15) ? 4'd15 : v[3:0];
  endfunction

  task automatic push_exp();
    for (int i = 0; i < 256; i++) begin
      q32.push_back({i[7:0], hist[i]});
      q4.push_back({i[7:0], sat4(hist[i])});
      hist[i] = 0;
    end
  endtask

  task automatic readout();
    push_exp();
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("valid_r1", a_valid, 1'b0);
    tick();
    chk("valid_r2", a_valid, 1'b1);
    repeat (262) tick();
    chk("q32_empty", q32.size(), 0);
    chk("q4_empty", q4.size(), 0);
  endtask

  // counted=0 means the frame starts in a busy state and must be dropped
  task automatic send_frame(input logic [7:0] px [$], input bit counted,
                            input bit req_mid);
    int n;
    vsync = 1'b1;
    tick();
    if (!counted) chk("drop_pulse", a_drop, 1'b1);
    for (int i = 0; i < px.size(); i++) begin
      hsync = 1'b1;
      data  = px[i];
      req   = req_mid && (i == 1);
      if (counted) hist[px[i]]++;
      tick();
    end
    req   = 1'b0;
    data  = 8'd200;
    vsync = 1'b0;
    tick();
    hsync = 1'b0;
    if (counted) begin
      n = 0;
      while (!a_done && n < 10) begin
        tick();
        n++;
      end
      chk("wr_done", a_done, 1'b1);
`ifdef HIST_TOTAL_CNT_EN
      chk("total32", a_tot, px.size());
      chk("total4", b_tot, sat4(px.size()));
`endif
      tick();
      chk("rd_ready", a_rdy, 1'b1);
      chk("wr_done_1cyc", a_done, 1'b0);
    end else begin
      repeat (6) tick();
    end
  endtask

  initial begin
    logic [7:0] px [$];
    int pulses;
    for (int i = 0; i < 256; i++) hist[i] = 0;

    tick();
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_pix", a_pix, 8'd0);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_rdy", a_rdy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_drop", a_drop, 1'b0);
    rst_n = 1'b1;

    repeat (10) tick();
    vsync = 1'b1;
    tick();
    chk("drop_clear", a_drop, 1'b1);
    tick();
    chk("drop_1cyc", a_drop, 1'b0);
    pulses = 0;
    for (int i = 0; i < 320; i++) begin
      if (i == 300) vsync = 1'b0;
      tick();
      pulses += int'(a_rdy) + int'(a_done);
    end
    chk("no_ready_dropped", pulses, 0);

    px = '{8'd5, 8'd5, 8'd5, 8'd7, 8'd0, 8'd255, 8'd5, 8'd7};
    send_frame(px, 1'b1, 1'b0);
    readout();

    px.delete();
    for (int i = 0; i < 160 * 120; i++) px.push_back(8'd128);
    send_frame(px, 1'b1, 1'b0);
    readout();

    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("req_wait_r2", a_valid, 1'b0);
    tick();
    chk("req_wait_r3", a_valid, 1'b0);

    px = '{8'd1, 8'd2, 8'd2, 8'd3};
    send_frame(px, 1'b1, 1'b1);
    chk("req_count", a_valid, 1'b0);
    px = '{8'd2, 8'd2, 8'd9};
    send_frame(px, 1'b0, 1'b0);
    readout();

    px = '{8'd100, 8'd100, 8'd50};
    send_frame(px, 1'b1, 1'b0);
    push_exp();
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    repeat (100) tick();
    chk("abort_at_100", a_pix, 8'd100);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", a_valid, 1'b0);
    chk("abort_cnt", a_cnt, 32'd0);
    q32.delete();
    q4.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (270) tick();
    px = '{8'd3, 8'd3};
    send_frame(px, 1'b1, 1'b0);
    readout();

    px.delete();
    for (int i = 0; i < 20; i++) px.push_back(8'd9);
    send_frame(px, 1'b1, 1'b0);
    readout();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
